bus_err_tap: RTL and testbench

BUS_ERR_TAP -- requirements
Module: bus_err_tap

---
 rtl/bus_err_tap_if.sv | 49 ++++
 rtl/bus_err_tap.sv | 199 +++++++++++++++++++
 tb/tb_bus_err_tap.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_err_tap_if.sv
// bus_err_tap_if: bundle of the read/write handshake signals that pass
// through the error tap.
//   slave  modport - the tap's view: sees upstream valids/addresses and
//                    downstream readies/responses, drives the gated copies.
//   master modport - the surrounding bus fabric (or a bench) view.
// Signal names keep their direction affixes as seen from the tap.
interface bus_err_tap_if #(
  parameter int AddrWidth = 48
) ();
  logic                 slv_ar_valid_i;
  logic                 mst_ar_valid_o;
  logic                 mst_ar_ready_i;
  logic                 slv_ar_ready_o;
  logic [AddrWidth-1:0] slv_ar_addr_i;
  logic                 slv_aw_valid_i;
  logic                 mst_aw_valid_o;
  logic                 mst_aw_ready_i;
  logic                 slv_aw_ready_o;
  logic [AddrWidth-1:0] slv_aw_addr_i;
  logic                 mst_r_valid_i;
  logic                 slv_r_valid_o;
  logic                 slv_r_ready_i;
  logic                 mst_r_ready_o;
  logic                 mst_r_last_i;
  logic [1:0]           mst_r_resp_i;
  logic                 mst_b_valid_i;
  logic                 slv_b_valid_o;
  logic                 slv_b_ready_i;
  logic                 mst_b_ready_o;
  logic [1:0]           mst_b_resp_i;

  modport slave (
    input  slv_ar_valid_i, mst_ar_ready_i, slv_ar_addr_i,
    input  slv_aw_valid_i, mst_aw_ready_i, slv_aw_addr_i,
    input  mst_r_valid_i, slv_r_ready_i, mst_r_last_i, mst_r_resp_i,
    input  mst_b_valid_i, slv_b_ready_i, mst_b_resp_i,
    output mst_ar_valid_o, slv_ar_ready_o, mst_aw_valid_o, slv_aw_ready_o,
    output slv_r_valid_o, mst_r_ready_o, slv_b_valid_o, mst_b_ready_o
  );

  modport master (
    output slv_ar_valid_i, mst_ar_ready_i, slv_ar_addr_i,
    output slv_aw_valid_i, mst_aw_ready_i, slv_aw_addr_i,
    output mst_r_valid_i, slv_r_ready_i, mst_r_last_i, mst_r_resp_i,
    output mst_b_valid_i, slv_b_ready_i, mst_b_resp_i,
    input  mst_ar_valid_o, slv_ar_ready_o, mst_aw_valid_o, slv_aw_ready_o,
    input  slv_r_valid_o, mst_r_ready_o, slv_b_valid_o, mst_b_ready_o
  );
endinterface

// File: rtl/bus_err_tap.sv
// bus_err_tap: passive-ish tap on a read (ch0) / write (ch1) bus that turns
// address handshakes into request events and completed bursts into response
// events carrying an accumulated error code, with a per-channel timeout.
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   bus                - AR/AW/R/B handshakes (bus_err_tap_if.slave)
//   req_hs_valid_o[1:0], req_addr_o   - one-hot request event + address
//   rsp_hs_valid_o[1:0], rsp_burst_last_o[1:0], rsp_err_o[2:0]
//                      - one-hot response event, burst-last, error code
//                        (bit0 SLVERR, bit1 DECERR, bit2 timed out)
//   timeout_o[1:0]     - single-cycle per-channel timeout pulse
module bus_err_tap #(
  parameter int AddrWidth      = 48,
  parameter int NumOutstanding = 4,
  parameter int TimeoutCycles  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  bus_err_tap_if.slave         bus,
  output logic [1:0]           req_hs_valid_o,
  output logic [AddrWidth-1:0] req_addr_o,
  output logic [1:0]           rsp_hs_valid_o,
  output logic [1:0]           rsp_burst_last_o,
  output logic [2:0]           rsp_err_o,
  output logic [1:0]           timeout_o
);
  localparam int CW = $clog2(NumOutstanding + 1);
  localparam int TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CW-1:0] CntMax = CW'(NumOutstanding);
  localparam logic [TW-1:0] ToLast = TW'(TimeoutCycles - 1);
  localparam logic [TW-1:0] ToPre  = TW'(TimeoutCycles - 2);

  logic [1:0]                req_vld_r;
  logic [1:0][AddrWidth-1:0] req_addr_r;
  logic [1:0]                rsp_vld_r;
  logic [1:0][2:0]           rsp_err_r;
  logic [1:0][CW-1:0]        cnt_r;
  logic [1:0]                rd_acc_r;
  logic [1:0][TW-1:0]        to_cnt_r;
  logic [1:0]                to_flag_r;
  logic [1:0]                to_pulse_r;
  logic                      req_rr_r;
  logic                      rsp_rr_r;

  logic [1:0]                req_gnt_s, rsp_elig_s, rsp_gnt_s;
  logic [1:0]                a_stall_s, a_hs_s, beat_s, done_s, to_hit_s;
  logic                      r_stall_s, b_stall_s;
  logic [1:0][AddrWidth-1:0] a_addr_s;
  logic [1:0][2:0]           new_err_s;

  // AXI response code to error bits: SLVERR -> bit0, DECERR -> bit1.
  function automatic logic [1:0] map_resp(input logic [1:0] resp);
    logic [1:0] bits;
    case (resp)
      2'b10:   bits = 2'b01;
      2'b11:   bits = 2'b10;
      default: bits = 2'b00;
    endcase
    return bits;
  endfunction

  // Request slot arbiter: round-robin only when both slots are occupied.
  always_comb begin
    req_gnt_s = 2'b00;
    if (req_vld_r == 2'b11) begin
      req_gnt_s = req_rr_r ? 2'b10 : 2'b01;
    end else begin
      req_gnt_s = req_vld_r;
    end
  end

  // Response slot arbiter: a response waits until its own request has drained.
  always_comb begin
    rsp_elig_s = rsp_vld_r & ~req_vld_r;
    rsp_gnt_s  = 2'b00;
    if (rsp_elig_s == 2'b11) begin
      rsp_gnt_s = rsp_rr_r ? 2'b10 : 2'b01;
    end else begin
      rsp_gnt_s = rsp_elig_s;
    end
  end

  // Stall gates and passed handshakes; stalls depend on registers only.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      a_stall_s[c] = (req_vld_r[c] & ~req_gnt_s[c]) | (cnt_r[c] == CntMax);
    end
    r_stall_s   = rsp_vld_r[0] & ~rsp_gnt_s[0];
    b_stall_s   = rsp_vld_r[1] & ~rsp_gnt_s[1];
    a_hs_s[0]   = bus.slv_ar_valid_i & bus.mst_ar_ready_i & ~a_stall_s[0];
    a_hs_s[1]   = bus.slv_aw_valid_i & bus.mst_aw_ready_i & ~a_stall_s[1];
    a_addr_s[0] = bus.slv_ar_addr_i;
    a_addr_s[1] = bus.slv_aw_addr_i;
    beat_s[0]   = bus.mst_r_valid_i & bus.slv_r_ready_i & ~r_stall_s;
    beat_s[1]   = bus.mst_b_valid_i & bus.slv_b_ready_i & ~b_stall_s;
    done_s[0]   = beat_s[0] & bus.mst_r_last_i;
    done_s[1]   = beat_s[1];
    new_err_s[0] = {to_flag_r[0], rd_acc_r | map_resp(bus.mst_r_resp_i)};
    new_err_s[1] = {to_flag_r[1], map_resp(bus.mst_b_resp_i)};
    for (int c = 0; c < 2; c++) begin
      to_hit_s[c] = (cnt_r[c] != {CW{1'b0}}) & ~beat_s[c] & (to_cnt_r[c] == ToPre);
    end
  end

  assign bus.mst_ar_valid_o = bus.slv_ar_valid_i & ~a_stall_s[0];
  assign bus.slv_ar_ready_o = bus.mst_ar_ready_i & ~a_stall_s[0];
  assign bus.mst_aw_valid_o = bus.slv_aw_valid_i & ~a_stall_s[1];
  assign bus.slv_aw_ready_o = bus.mst_aw_ready_i & ~a_stall_s[1];
  assign bus.slv_r_valid_o  = bus.mst_r_valid_i & ~r_stall_s;
  assign bus.mst_r_ready_o  = bus.slv_r_ready_i & ~r_stall_s;
  assign bus.slv_b_valid_o  = bus.mst_b_valid_i & ~b_stall_s;
  assign bus.mst_b_ready_o  = bus.slv_b_ready_i & ~b_stall_s;

  assign req_hs_valid_o   = req_gnt_s;
  assign rsp_hs_valid_o   = rsp_gnt_s;
  assign rsp_burst_last_o = rsp_gnt_s;
  assign timeout_o        = to_pulse_r;

  // Event payload muxes, zero when nothing drains.
  always_comb begin
    case (req_gnt_s)
      2'b01:   req_addr_o = req_addr_r[0];
      2'b10:   req_addr_o = req_addr_r[1];
      default: req_addr_o = {AddrWidth{1'b0}};
    endcase
    case (rsp_gnt_s)
      2'b01:   rsp_err_o = rsp_err_r[0];
      2'b10:   rsp_err_o = rsp_err_r[1];
      default: rsp_err_o = 3'b000;
    endcase
  end

  // Slots, outstanding counts and round-robin pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_vld_r  <= 2'b00;
      req_addr_r <= '0;
      rsp_vld_r  <= 2'b00;
      rsp_err_r  <= '0;
      cnt_r      <= '0;
      req_rr_r   <= 1'b0;
      rsp_rr_r   <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        // A new load wins over the drain of the previous content.
        if (a_hs_s[c]) begin
          req_vld_r[c]  <= 1'b1;
          req_addr_r[c] <= a_addr_s[c];
        end else if (req_gnt_s[c]) begin
          req_vld_r[c] <= 1'b0;
        end
        if (done_s[c]) begin
          rsp_vld_r[c] <= 1'b1;
          rsp_err_r[c] <= new_err_s[c];
        end else if (rsp_gnt_s[c]) begin
          rsp_vld_r[c] <= 1'b0;
        end
        case ({a_hs_s[c], done_s[c]})
          2'b10:   if (cnt_r[c] != CntMax) cnt_r[c] <= cnt_r[c] + CW'(1);
          2'b01:   if (cnt_r[c] != {CW{1'b0}}) cnt_r[c] <= cnt_r[c] - CW'(1);
          default: cnt_r[c] <= cnt_r[c];
        endcase
      end
      // Pointer names the channel that wins the next two-way contest.
      if (req_gnt_s != 2'b00) req_rr_r <= req_gnt_s[0];
      if (rsp_gnt_s != 2'b00) rsp_rr_r <= rsp_gnt_s[0];
    end
  end

  // Read error accumulation and per-channel response timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_acc_r   <= 2'b00;
      to_cnt_r   <= '0;
      to_flag_r  <= 2'b00;
      to_pulse_r <= 2'b00;
    end else begin
      if (done_s[0]) begin
        rd_acc_r <= 2'b00;
      end else if (beat_s[0]) begin
        rd_acc_r <= rd_acc_r | map_resp(bus.mst_r_resp_i);
      end
      for (int c = 0; c < 2; c++) begin
        to_pulse_r[c] <= to_hit_s[c];
        if ((cnt_r[c] == {CW{1'b0}}) || beat_s[c]) begin
          to_cnt_r[c] <= {TW{1'b0}};
        end else if (to_cnt_r[c] != ToLast) begin
          to_cnt_r[c] <= to_cnt_r[c] + TW'(1);
        end
        // Sticky flag lives until the burst it belongs to completes.
        if (done_s[c]) begin
          to_flag_r[c] <= 1'b0;
        end else if (to_hit_s[c]) begin
          to_flag_r[c] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bus_err_tap.sv
// tb_bus_err_tap: directed stimulus with a queue-based scoreboard for
// request and response events; a negedge monitor pops and compares.
module tb_bus_err_tap;
  localparam int AW = 48;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_err_tap_if #(.AddrWidth(AW)) bif ();
  logic [1:0]    req_hs_valid, rsp_hs_valid, rsp_burst_last, timeout;
  logic [AW-1:0] req_addr;
  logic [2:0]    rsp_err;

  bus_err_tap #(.AddrWidth(AW), .NumOutstanding(4), .TimeoutCycles(1024)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bif),
    .req_hs_valid_o(req_hs_valid), .req_addr_o(req_addr),
    .rsp_hs_valid_o(rsp_hs_valid), .rsp_burst_last_o(rsp_burst_last),
    .rsp_err_o(rsp_err), .timeout_o(timeout)
  );

  typedef struct { logic [1:0] vld; logic [AW-1:0] addr; int at; } req_exp_t;
  typedef struct { logic [1:0] vld; logic [2:0] err; int at; } rsp_exp_t;
  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: compare every presented event against the queues.
  always @(negedge clk) begin
    req_exp_t re;
    rsp_exp_t se;
    if (req_hs_valid !== 2'b00) begin
      if (req_q.size() == 0) begin
        chk("unexpected_req", {62'd0, req_hs_valid}, 64'd0);
      end else begin
        re = req_q.pop_front();
        chk("req_valid", {62'd0, req_hs_valid}, {62'd0, re.vld});
        chk("req_addr", {16'd0, req_addr}, {16'd0, re.addr});
        if (re.at >= 0) chk("req_cycle", 64'(cyc), 64'(re.at));
      end
    end
    if (rsp_hs_valid !== 2'b00) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", {62'd0, rsp_hs_valid}, 64'd0);
      end else begin
        se = rsp_q.pop_front();
        chk("rsp_valid", {62'd0, rsp_hs_valid}, {62'd0, se.vld});
        chk("rsp_last", {62'd0, rsp_burst_last}, {62'd0, se.vld});
        chk("rsp_err", {61'd0, rsp_err}, {61'd0, se.err});
        if (se.at >= 0) chk("rsp_cycle", 64'(cyc), 64'(se.at));
      end
    end
  end

  task automatic exp_req(input logic [1:0] v, input logic [AW-1:0] a, input int at);
    req_exp_t e;
    e.vld = v; e.addr = a; e.at = at;
    req_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [1:0] v, input logic [2:0] err, input int at);
    rsp_exp_t e;
    e.vld = v; e.err = err; e.at = at;
    rsp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bif.slv_ar_valid_i = 1'b0; bif.slv_ar_addr_i = '0; bif.mst_ar_ready_i = 1'b1;
    bif.slv_aw_valid_i = 1'b0; bif.slv_aw_addr_i = '0; bif.mst_aw_ready_i = 1'b1;
    bif.mst_r_valid_i = 1'b0; bif.mst_r_last_i = 1'b0; bif.mst_r_resp_i = 2'b00;
    bif.slv_r_ready_i = 1'b1;
    bif.mst_b_valid_i = 1'b0; bif.mst_b_resp_i = 2'b00; bif.slv_b_ready_i = 1'b1;
  endtask

  // Wait (bounded) for the handshake on channel ch (0 AR, 1 AW, 2 R, 3 B),
  // whose valid is already raised; returns the cycle the slot was loaded.
  task automatic wait_ready(input int ch, output int hs);
    bit got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      case (ch)
        0: got = bif.slv_ar_ready_o;
        1: got = bif.slv_aw_ready_o;
        2: got = bif.mst_r_ready_o;
        default: got = bif.mst_b_ready_o;
      endcase
      @(posedge clk);
      #1;
    end
    hs = cyc;
    case (ch)
      0: bif.slv_ar_valid_i = 1'b0;
      1: bif.slv_aw_valid_i = 1'b0;
      2: bif.mst_r_valid_i = 1'b0;
      default: bif.mst_b_valid_i = 1'b0;
    endcase
    if (!got) chk("handshake_bound", 64'd0, 64'd1);
  endtask

  task automatic ar_send(input logic [AW-1:0] a, output int hs);
    bif.slv_ar_valid_i = 1'b1; bif.slv_ar_addr_i = a;
    wait_ready(0, hs);
  endtask

  task automatic r_beat(input logic [1:0] resp, input logic last, output int hs);
    bif.mst_r_valid_i = 1'b1; bif.mst_r_resp_i = resp; bif.mst_r_last_i = last;
    wait_ready(2, hs);
  endtask

  task automatic b_send(input logic [1:0] resp, output int hs);
    bif.mst_b_valid_i = 1'b1; bif.mst_b_resp_i = resp;
    wait_ready(3, hs);
  endtask

  // Single AR then a four-beat read burst whose third beat is SLVERR.
  task automatic burst_with_slverr(input logic [AW-1:0] a);
    int hs;
    logic [7:0] resps = 8'b00_10_00_00;
    ar_send(a, hs);
    exp_req(2'b01, a, hs);
    for (int b = 0; b < 4; b++) begin
      r_beat(resps[2*b +: 2], (b == 3), hs);
    end
    exp_rsp(2'b01, 3'b001, hs);
  endtask

  initial begin
    int hs, hs2, first_to, pulses;
    rsp_exp_t dummy;
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_req_valid", {62'd0, req_hs_valid}, 64'd0);
    chk("rst_rsp_valid", {62'd0, rsp_hs_valid}, 64'd0);
    chk("rst_timeout", {62'd0, timeout}, 64'd0);
    chk("rst_rsp_err", {61'd0, rsp_err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ar_ready", {63'd0, bif.slv_ar_ready_o}, 64'd1);
    chk("idle_b_ready", {63'd0, bif.mst_b_ready_o}, 64'd1);
    chk("idle_ar_valid", {63'd0, bif.mst_ar_valid_o}, 64'd0);
    @(posedge clk); #1;

    // Simultaneous AR/AW: read first, write one cycle later.
    bif.slv_ar_valid_i = 1'b1; bif.slv_ar_addr_i = 48'hA0;
    bif.slv_aw_valid_i = 1'b1; bif.slv_aw_addr_i = 48'hB0;
    @(negedge clk);
    chk("sim_ar_valid_pass", {63'd0, bif.mst_ar_valid_o}, 64'd1);
    chk("sim_aw_ready", {63'd0, bif.slv_aw_ready_o}, 64'd1);
    @(posedge clk); #1;
    hs = cyc;
    bif.slv_ar_valid_i = 1'b0; bif.slv_aw_valid_i = 1'b0;
    exp_req(2'b01, 48'hA0, hs);
    exp_req(2'b10, 48'hB0, hs + 1);
    @(negedge clk);
    chk("aw_stall_first", {63'd0, bif.slv_aw_ready_o}, 64'd0);
    @(negedge clk);
    chk("aw_stall_released", {63'd0, bif.slv_aw_ready_o}, 64'd1);
    @(posedge clk); #1;
    r_beat(2'b00, 1'b1, hs);
    exp_rsp(2'b01, 3'b000, hs);
    b_send(2'b00, hs);
    exp_rsp(2'b10, 3'b000, hs);
    repeat (3) @(posedge clk); #1;

    // Four-beat read burst with an SLVERR beat.
    burst_with_slverr(48'h1000);
    repeat (3) @(posedge clk); #1;

    // AR/AW together with write winning; R-last lands while read slot waits.
    bif.slv_ar_valid_i = 1'b1; bif.slv_ar_addr_i = 48'hC0;
    bif.slv_aw_valid_i = 1'b1; bif.slv_aw_addr_i = 48'hD0;
    @(posedge clk); #1;
    hs = cyc;
    bif.slv_ar_valid_i = 1'b0; bif.slv_aw_valid_i = 1'b0;
    exp_req(2'b10, 48'hD0, hs);
    exp_req(2'b01, 48'hC0, hs + 1);
    r_beat(2'b11, 1'b1, hs2);
    exp_rsp(2'b01, 3'b010, hs + 2);
    repeat (4) @(posedge clk); #1;
    b_send(2'b10, hs);
    exp_rsp(2'b10, 3'b001, hs);
    repeat (3) @(posedge clk); #1;

    // Outstanding limit: fifth AR held until one read burst completes.
    for (int i = 0; i < 4; i++) begin
      ar_send(48'h100 + 48'(i * 16), hs);
      exp_req(2'b01, 48'h100 + 48'(i * 16), hs);
    end
    bif.slv_ar_valid_i = 1'b1; bif.slv_ar_addr_i = 48'h140;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ar5_held", {63'd0, bif.slv_ar_ready_o}, 64'd0);
    end
    @(posedge clk); #1;
    r_beat(2'b00, 1'b1, hs);
    exp_rsp(2'b01, 3'b000, hs);
    wait_ready(0, hs2);
    chk("ar5_release_cycle", 64'(hs2), 64'(hs + 1));
    exp_req(2'b01, 48'h140, hs2);
    for (int i = 0; i < 4; i++) begin
      r_beat(2'b00, 1'b1, hs);
      exp_rsp(2'b01, 3'b000, hs);
    end
    repeat (3) @(posedge clk); #1;

    // Write timeout, then a late OKAY carries the timeout bit.
    bif.slv_aw_valid_i = 1'b1; bif.slv_aw_addr_i = 48'hE0;
    wait_ready(1, hs);
    exp_req(2'b10, 48'hE0, hs);
    pulses = 0;
    first_to = -1;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (timeout !== 2'b00) begin
        pulses++;
        if (first_to < 0) first_to = cyc;
        chk("timeout_value", {62'd0, timeout}, 64'd2);
      end
    end
    chk("timeout_pulse_count", 64'(pulses), 64'd1);
    chk("timeout_window", 64'((first_to >= hs + 1000) && (first_to <= hs + 1030)), 64'd1);
    @(posedge clk); #1;
    b_send(2'b00, hs);
    exp_rsp(2'b10, 3'b100, hs);
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of a read burst discards everything.
    ar_send(48'h2000, hs);
    exp_req(2'b01, 48'h2000, hs);
    r_beat(2'b11, 1'b0, hs);
    r_beat(2'b10, 1'b0, hs);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_valid", {62'd0, req_hs_valid}, 64'd0);
    chk("mid_rst_rsp_valid", {62'd0, rsp_hs_valid}, 64'd0);
    chk("mid_rst_rsp_err", {61'd0, rsp_err}, 64'd0);
    chk("mid_rst_req_addr", {16'd0, req_addr}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    burst_with_slverr(48'h1000);
    repeat (5) @(posedge clk); #1;

    chk("req_queue_drained", 64'(req_q.size()), 64'd0);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    while (rsp_q.size() > 0) dummy = rsp_q.pop_front();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
